// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply (radix-2 Booth) and signed divide
// (restoring division on magnitudes with a final sign fix-up).
// A request is taken in IDLE. The unit then runs 32 iterations in RUN and
// publishes the 64-bit result in DONE.
// A divide by zero skips RUN and publishes its fixed result after one cycle.
module mul_div_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Zhigh,
  output logic [31:0] Zlow,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] hi_q, hi_d;        // MUL: Booth accumulator, DIV: partial remainder
  logic [31:0] lo_q, lo_d;        // MUL: multiplier/product low, DIV: dividend/quotient
  logic        qm1_q, qm1_d;      // Booth q_-1 bit
  logic [31:0] mcand_q, mcand_d;  // MUL: multiplicand, DIV: |divisor|
  logic        qneg_q, qneg_d;    // quotient must be negated at the end
  logic        rneg_q, rneg_d;    // remainder must be negated (dividend was negative)
  logic [31:0] zhigh_q, zhigh_d;
  logic [31:0] zlow_q, zlow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  // One-iteration datapath results.
  logic [32:0] booth_sum_s;
  logic [31:0] mul_hi_s;
  logic [31:0] mul_lo_s;
  logic [32:0] rem_shift_s;
  logic [31:0] div_hi_s;
  logic [31:0] div_lo_s;

  // Magnitude of a two's complement value; -2^31 maps to 0x80000000 unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Two's complement negation, used only when the flag asks for it.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  // One Booth step and one restoring-division step from the current working registers.
  always_comb begin
    booth_sum_s = {hi_q[31], hi_q};
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum_s = {hi_q[31], hi_q} + {mcand_q[31], mcand_q};
      2'b10:   booth_sum_s = {hi_q[31], hi_q} - {mcand_q[31], mcand_q};
      default: booth_sum_s = {hi_q[31], hi_q};
    endcase
    // The 33-bit sum keeps the true sign, so the arithmetic shift stays exact
    // even for -2^31 * -2^31.
    mul_hi_s    = booth_sum_s[32:1];
    mul_lo_s    = {booth_sum_s[0], lo_q[31:1]};

    rem_shift_s = {hi_q, lo_q[31]};
    if (rem_shift_s >= {1'b0, mcand_q}) begin
      div_hi_s = 32'(rem_shift_s - {1'b0, mcand_q});
      div_lo_s = {lo_q[30:0], 1'b1};
    end else begin
      div_hi_s = rem_shift_s[31:0];
      div_lo_s = {lo_q[30:0], 1'b0};
    end
  end

  // Next-state, working-register and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zhigh_d = zhigh_q;
    zlow_d  = zlow_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = 5'd0;
          qm1_d  = 1'b0;
          hi_d   = 32'd0;
          dbz_d  = 1'b0;
          busy_d = 1'b1;
          if (op) begin
            lo_d    = abs32(A);
            mcand_d = abs32(B);
            qneg_d  = A[31] ^ B[31];
            rneg_d  = A[31];
            if (B == 32'd0) begin
              // The divide-by-zero result is fixed, so it is published on the next edge.
              state_d = DONE;
              done_d  = 1'b1;
              dbz_d   = 1'b1;
              zhigh_d = A;
              zlow_d  = 32'hFFFF_FFFF;
            end else begin
              state_d = RUN;
            end
          end else begin
            lo_d    = B;
            mcand_d = A;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (op_q) begin
          hi_d = div_hi_s;
          lo_d = div_lo_s;
        end else begin
          hi_d  = mul_hi_s;
          lo_d  = mul_lo_s;
          qm1_d = lo_q[0];
        end
        if (cnt_q == 5'd31) begin
          // The last iteration loads the result so that it is valid while done is high.
          state_d = DONE;
          done_d  = 1'b1;
          if (op_q) begin
            zhigh_d = neg_if(div_hi_s, rneg_q);
            zlow_d  = neg_if(div_lo_s, qneg_q);
          end else begin
            zhigh_d = mul_hi_s;
            zlow_d  = mul_lo_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers with a synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      qm1_q   <= 1'b0;
      mcand_q <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zhigh_q <= 32'd0;
      zlow_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zhigh_q <= zhigh_d;
      zlow_q  <= zlow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Zhigh       = zhigh_q;
  assign Zlow        = zlow_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle signed multiply/divide unit for the datapath ALU. It takes operand A (from register Y) and operand B (from BusMuxOut) and produces a 64-bit result. The result is held in the Zhigh/Zlow values that the bus mux drives back onto the bus when Zhighout/Zlowout are asserted. The control unit starts an operation with a one-cycle pulse and waits for `done` before enabling Zhighout/Zlowout.

## Interface
- No parameters; data width fixed at 32 bits, result width 64.
- clock  in  1  single system clock; all state changes on rising edge.
- clear  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clock).
- start  in  1  one-cycle request; accepted only in IDLE.
- op  in  1  0 = signed multiply (MUL), 1 = signed divide (DIV); sampled with start.
- A  in  32  multiplicand / dividend (two's complement); sampled with start.
- B  in  32  multiplier / divisor (two's complement); sampled with start.
- Zhigh  out  32  MUL: product[63:32]; DIV: remainder.
- Zlow  out  32  MUL: product[31:0]; DIV: quotient.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; Zhigh/Zlow are valid from this cycle on.
- div_by_zero  out  1  set with done when a DIV had B = 0; cleared on the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch A, B, op; iteration counter = 0; go to RUN. Exception: op=1 and B=0 goes directly to DONE.
- IDLE, start=0: remain in IDLE.
- RUN: one iteration per cycle; after the 32nd iteration (counter == 31), go to DONE.
- DONE: load Zhigh/Zlow from the working registers and pulse done; go to IDLE.
- start in RUN or DONE is ignored; no queuing.
- MUL algorithm: radix-2 Booth over 32 bits.
  - 65-bit working register {acc[31:0], q[31:0], q_-1}.
  - Each iteration: add or subtract the sign-extended multiplicand per {q0, q_-1}, then arithmetic shift right by 1.
  - Result is the exact 64-bit signed product. Overflow is impossible, including -2^31 × -2^31.
- DIV algorithm: restoring division on magnitudes |A|, |B| (33-bit intermediate), then sign fix-up in DONE.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives Zlow = 0x80000000 (wraps) and Zhigh = 0; no flag.
- Divide by zero: Zlow = 0xFFFFFFFF, Zhigh = A, div_by_zero = 1.
- Zhigh/Zlow change only in DONE or on reset; otherwise they hold the last result, even while busy.

## Timing
- Reset (clear=0 at an edge), from any state including mid-operation:
  - state returns to IDLE;
  - Zhigh = 0, Zlow = 0, busy = 0, done = 0, div_by_zero = 0;
  - the in-progress operation is discarded.
- Start accepted at edge T (normal MUL/DIV):
  - busy = 1 during cycles T+1 … T+33;
  - done = 1 in cycle T+33 only;
  - Zhigh/Zlow are new from T+33; busy = 0 from T+34.
  - Latency is 33 cycles from start to done.
- Divide by zero, accepted at T: done = 1 and results valid at T+1; busy = 1 only in T+1; latency 1 cycle.
- Back-to-back operation: start held high through done is accepted at the first IDLE edge after done, so done-to-next-start spacing is 1 cycle.
- done and busy are both high in the DONE cycle.
- done never asserts without a preceding accepted start.

## Test plan
- MUL: A=7, B=-3 (0xFFFFFFFD), start pulse -> done at start+33; Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFEB; busy high for exactly 33 cycles.
- MUL corners:
  - A=B=0x80000000 -> Zhigh=0x40000000, Zlow=0x00000000.
  - A=0xFFFFFFFF, B=0xFFFFFFFF -> Zhigh=0, Zlow=1.
- DIV signs:
  - -7/2 -> Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF.
  - 7/-2 -> Zlow=0xFFFFFFFD, Zhigh=1.
  - 0x80000000/0xFFFFFFFF -> Zlow=0x80000000, Zhigh=0.
- Divide by zero: op=1, A=0x12345678, B=0 -> done one cycle after start; Zlow=0xFFFFFFFF, Zhigh=0x12345678, div_by_zero=1. A following MUL 2×3 clears the flag and gives Zlow=6.
- Ignored start: start MUL 5×5, pulse start with op=1 at cycle +10 -> still exactly one done at +33 with Zlow=25; no second done.
- Reset mid-operation: start DIV 100/7, drive clear=0 at cycle +15 -> next cycle all outputs 0 and state IDLE; no done. A new start of 100/7 -> Zlow=14, Zhigh=2 after 33 cycles.
